// File: rtl/axi_mem_master_if.sv
// AXI response encoding and the AXI bus bundle between the bridge and the peripheral slaves.
package BusPack;
  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;
endpackage

interface Axi_ift #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  b_valid;
  logic                  b_ready;
  BusPack::resp_t        b_resp;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  BusPack::resp_t        r_resp;

  modport Master (
    output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport Slave (
    input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_mem_master.sv
// Single-outstanding bridge: one core load/store request becomes one AXI write or read.
module axi_mem_master #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wen,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wmask,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  Axi_ift.Master                    mem_ift
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  b_ready_q, b_ready_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;

  // Next state, latched request fields, and next values of every registered output
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wmask_d   = req_wmask;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen ? WRITE : RADDR;
        end
      end
      WRITE: begin
        aw_done_d = aw_done_q | (aw_valid_q & mem_ift.aw_ready);
        w_done_d  = w_done_q  | (w_valid_q  & mem_ift.w_ready);
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (b_ready_q && mem_ift.b_valid) begin
          err_d   = (mem_ift.b_resp != BusPack::OKAY);
          state_d = DONE;
        end
      end
      RADDR: begin
        if (ar_valid_q && mem_ift.ar_ready) state_d = RDATA;
      end
      RDATA: begin
        if (r_ready_q && mem_ift.r_valid) begin
          rdata_d = mem_ift.r_data;
          err_d   = (mem_ift.r_resp != BusPack::OKAY);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A channel valid stays low once its own handshake has completed
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    aw_valid_d   = (state_d == WRITE) && !aw_done_d;
    w_valid_d    = (state_d == WRITE) && !w_done_d;
    b_ready_d    = (state_d == WRESP);
    ar_valid_d   = (state_d == RADDR);
    r_ready_d    = (state_d == RDATA);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      b_ready_q    <= b_ready_d;
      ar_valid_q   <= ar_valid_d;
      r_ready_q    <= r_ready_d;
    end
  end

  // Port and bus drives, all straight from registers
  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_err         = err_q;
  assign mem_ift.aw_valid = aw_valid_q;
  assign mem_ift.aw_addr  = addr_q;
  assign mem_ift.w_valid  = w_valid_q;
  assign mem_ift.w_data   = wdata_q;
  assign mem_ift.w_strb   = wmask_q;
  assign mem_ift.b_ready  = b_ready_q;
  assign mem_ift.ar_valid = ar_valid_q;
  assign mem_ift.ar_addr  = addr_q;
  assign mem_ift.r_ready  = r_ready_q;

endmodule
